writeback_pipe: RTL
===================

# writeback_pipe

Parametrised writeback stage with a valid/ready input handshake, a 2-entry skid buffer, byte-lane load alignment and extension, and a retired-instruction counter. It sits between the memory stage and the register file/fetch redirect. It commits at most one instruction per cycle, producing a register-file write, a fetch redirect, or both. Commits can be held off by a register-port stall, and the whole stage can be flushed.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values are 32 or 64.
- RI_W, 5: register index width.
- CNT_W, 32: retire counter width.
- OFF_W, $clog2(XLEN/8): byte-offset width (derived; not overridable).

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream holds an instruction
- in_ready  out  1  stage can accept; registered
- in_op_type  in  3  instruction class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP; 5–7 illegal
- in_op_spec  in  3  load funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- in_rd_ind  in  RI_W  destination register
- in_rd_dat  in  XLEN  ALU result, or link address for JUMP
- in_mem_dat  in  XLEN  raw aligned memory word
- in_mem_off  in  OFF_W  byte offset of the access within the word
- in_jmp_addr  in  XLEN  redirect target
- in_jmp_take  in  1  branch outcome
- flush  in  1  discard all held and incoming instructions
- wb_stall  in  1  register-file port unavailable this cycle
- wb_en  out  1  register-file write strobe
- wb_ind  out  RI_W  write index
- wb_dat  out  XLEN  write data
- jmp_take_out  out  1  fetch redirect strobe
- jmp_addr_out  out  XLEN  redirect target
- exc_out  out  1  illegal op or misaligned load committed
- retire_cnt  out  CNT_W  committed-instruction count

## Operation
- **Accept and store.** An instruction is accepted when in_valid && in_ready && !flush. The accepted fields are stored in a 2-entry FIFO. Entry 0 is the head.
- **in_ready.** in_ready is 0 exactly when both entries are valid. It is computed from registered occupancy.
- **Commit.** A commit occurs when the head is valid && !wb_stall && !flush. On commit the head pops and the tail moves to the head.
- **Simultaneous accept and commit.** Occupancy is unchanged.
- **Commit outputs.** All commit outputs are combinational from the head entry, gated by the commit condition. They are 0 in any cycle without a commit.
- **ALU.** wb_en = (wb_ind != 0); wb_dat = rd_dat.
- **LOAD.**
  - Extraction: shifted = mem_dat >> (8*mem_off).
  - Extension: lb/lh/lw sign-extend bits 7/15/31 to XLEN. lbu/lhu/lwu zero-extend. ld passes through.
  - wb_en = (wb_ind != 0).
- **Misaligned load.** A load is misaligned when:
  - lh/lhu has mem_off[0] != 0, or
  - lw/lwu has mem_off[1:0] != 0, or
  - ld has mem_off != 0.
  
  A misaligned load gives wb_en = 0 and exc_out = 1.
- **Illegal load spec.** ld/lwu when XLEN = 32, and spec 111, are illegal: wb_en = 0, exc_out = 1.
- **STORE.** No write and no redirect.
- **BRANCH.** jmp_take_out = jmp_take; jmp_addr_out = jmp_addr.
- **JUMP.** jmp_take_out = 1, plus the register write of rd_dat as for ALU.
- **Illegal op_type.** All strobes are 0 except exc_out = 1.
- **Retire counter.** retire_cnt increments by 1 on every commit, including exception commits. It wraps modulo 2^CNT_W.
- **Flush.** Both entries are invalidated at the next edge. The incoming instruction is dropped. No commit occurs in the flush cycle. in_ready = 1 on the following cycle.

## Timing
- **Reset.** The FIFO is empty and in_ready = 1. wb_en, jmp_take_out and exc_out are 0. wb_ind = 0, wb_dat = 0, jmp_addr_out = 0 and retire_cnt = 0.
  - Reset asserted mid-operation discards held entries immediately, without waiting for a clock edge.
- **Latency.** An instruction accepted at edge N commits in cycle N+1 if the FIFO was empty and wb_stall = 0.
  - Throughput is 1 per cycle with no bubbles.
- **Stall.** Each cycle of wb_stall adds one cycle of latency. The second accept fills the tail, and in_ready drops from the next cycle.
- **Release after a full stall.** in_ready rises in the cycle after the first commit.
- **Ordering.** Commits occur in acceptance order. Redirect and write for a JUMP happen in the same cycle.
- **flush with wb_stall.** flush wins.
- **Upstream hold rule.** Upstream must hold its inputs stable while in_valid && !in_ready.

## Test plan
- **Back-to-back ALU then reset value.** ALU rd=3, dat=0x1234 at edge 0 -> wb_en=1, wb_ind=3, wb_dat=0x1234 in cycle 1; retire_cnt=1. Then ALU rd=0 -> wb_en=0, retire_cnt=2.
- **Load extension.** mem_dat=0x80FF7F01:
  - lb off=3 -> 0xFFFFFF80
  - lbu off=1 -> 0x0000007F
  - lh off=2 -> 0xFFFF80FF
  - lhu off=2 -> 0x000080FF
  - lh off=1 -> wb_en=0, exc_out=1
- **Stall and full.** Hold wb_stall=1 and stream 3 ALU ops.
  - in_ready=0 after 2 accepts; the 3rd is held.
  - Release the stall -> 3 commits on consecutive cycles, in order, with in_ready re-rising after the first commit.
- **Redirects.**
  - BRANCH jmp_take=0 -> no strobes.
  - BRANCH jmp_take=1, addr=0x100 -> jmp_take_out=1, jmp_addr_out=0x100.
  - JUMP rd=1, dat=0x44 -> write plus redirect in the same cycle.
- **Flush and async reset.**
  - With 2 entries held, pulse flush with in_valid=1 -> zero commits; retire_cnt unchanged; in_ready=1 next cycle.
  - Assert rst between edges -> outputs return to reset values immediately.
- **Counter wrap and XLEN=64.** With CNT_W=4, 17 commits -> retire_cnt=1. With XLEN=64, ld off=0 passes through, and lwu off=4 on 0xFFFFFFFF_00000000 -> 0x00000000_FFFFFFFF.

Source files
------------

// File: rtl/writeback_pipe_if.sv
// Writeback stage bundle: upstream handshake, stage controls, and the
// register-file/redirect commit outputs.
interface writeback_pipe_if #(
  parameter int XLEN  = 32,
  parameter int RI_W  = 5,
  parameter int CNT_W = 32
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op_type;
  logic [2:0]       in_op_spec;
  logic [RI_W-1:0]  in_rd_ind;
  logic [XLEN-1:0]  in_rd_dat;
  logic [XLEN-1:0]  in_mem_dat;
  logic [OFF_W-1:0] in_mem_off;
  logic [XLEN-1:0]  in_jmp_addr;
  logic             in_jmp_take;
  logic             flush;
  logic             wb_stall;
  logic             wb_en;
  logic [RI_W-1:0]  wb_ind;
  logic [XLEN-1:0]  wb_dat;
  logic             jmp_take_out;
  logic [XLEN-1:0]  jmp_addr_out;
  logic             exc_out;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output in_valid, in_op_type, in_op_spec, in_rd_ind, in_rd_dat, in_mem_dat,
           in_mem_off, in_jmp_addr, in_jmp_take, flush, wb_stall,
    input  in_ready, wb_en, wb_ind, wb_dat, jmp_take_out, jmp_addr_out,
           exc_out, retire_cnt
  );

  modport slave (
    input  in_valid, in_op_type, in_op_spec, in_rd_ind, in_rd_dat, in_mem_dat,
           in_mem_off, in_jmp_addr, in_jmp_take, flush, wb_stall,
    output in_ready, wb_en, wb_ind, wb_dat, jmp_take_out, jmp_addr_out,
           exc_out, retire_cnt
  );
endinterface

// File: rtl/writeback_pipe.sv
// Writeback stage: 2-entry skid FIFO, load align/extend, commit decode and
// retired-instruction counter. Commit outputs are combinational off the head.
module writeback_pipe #(
  parameter int XLEN  = 32,
  parameter int RI_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  writeback_pipe_if.slave  bus
);
  localparam int OFF_W = $clog2(XLEN/8);

  localparam logic [2:0] OP_ALU    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_JUMP   = 3'd4;

  typedef struct packed {
    logic [2:0]       op_type;
    logic [2:0]       op_spec;
    logic [RI_W-1:0]  rd_ind;
    logic [XLEN-1:0]  rd_dat;
    logic [XLEN-1:0]  mem_dat;
    logic [OFF_W-1:0] mem_off;
    logic [XLEN-1:0]  jmp_addr;
    logic             jmp_take;
  } ent_t;

  ent_t             ent [2];
  logic [1:0]       vld;
  logic [CNT_W-1:0] cnt;
  ent_t             in_ent;
  logic             accept, commit;

  assign in_ent = '{op_type: bus.in_op_type, op_spec: bus.in_op_spec,
                    rd_ind: bus.in_rd_ind, rd_dat: bus.in_rd_dat,
                    mem_dat: bus.in_mem_dat, mem_off: bus.in_mem_off,
                    jmp_addr: bus.in_jmp_addr, jmp_take: bus.in_jmp_take};

  assign bus.in_ready   = ~&vld;
  assign accept         = bus.in_valid & bus.in_ready & ~bus.flush;
  assign commit         = vld[0] & ~bus.wb_stall & ~bus.flush;
  assign bus.retire_cnt = cnt;

  // vld[1] is only ever set while vld[0] is set, and the FIFO cannot accept
  // while full, so a commit with a valid tail never races an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      ent[0] <= '0;
      ent[1] <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      vld <= '0;
    end else begin
      if (commit) cnt <= cnt + 1'b1;
      if (commit) begin
        if (vld[1]) begin
          ent[0] <= ent[1];
          vld    <= 2'b01;
        end else if (accept) begin
          ent[0] <= in_ent;
          vld    <= 2'b01;
        end else begin
          vld    <= 2'b00;
        end
      end else if (accept) begin
        if (!vld[0]) begin
          ent[0] <= in_ent;
          vld[0] <= 1'b1;
        end else begin
          ent[1] <= in_ent;
          vld[1] <= 1'b1;
        end
      end
    end
  end

  ent_t            h;
  logic [XLEN-1:0] shifted, ld_val;
  logic            ld_bad;

  always_comb begin
    h       = ent[0];
    shifted = h.mem_dat >> {h.mem_off, 3'b000};
    ld_val  = shifted;
    ld_bad  = (h.op_spec == 3'b111) ||
              ((XLEN == 32) && (h.op_spec == 3'b011 || h.op_spec == 3'b110));
    // op_spec[1:0] is the access size, op_spec[2] selects zero extension.
    case (h.op_spec[1:0])
      2'd0: begin
        ld_val      = {XLEN{~h.op_spec[2] & shifted[7]}};
        ld_val[7:0] = shifted[7:0];
      end
      2'd1: begin
        ld_val       = {XLEN{~h.op_spec[2] & shifted[15]}};
        ld_val[15:0] = shifted[15:0];
        ld_bad       = ld_bad | h.mem_off[0];
      end
      2'd2: begin
        ld_val       = {XLEN{~h.op_spec[2] & shifted[31]}};
        ld_val[31:0] = shifted[31:0];
        ld_bad       = ld_bad | (|h.mem_off[1:0]);
      end
      default: ld_bad = ld_bad | (|h.mem_off);
    endcase

    bus.wb_en        = 1'b0;
    bus.wb_ind       = '0;
    bus.wb_dat       = '0;
    bus.jmp_take_out = 1'b0;
    bus.jmp_addr_out = '0;
    bus.exc_out      = 1'b0;
    if (commit) begin
      case (h.op_type)
        OP_ALU: begin
          bus.wb_en  = |h.rd_ind;
          bus.wb_ind = h.rd_ind;
          bus.wb_dat = h.rd_dat;
        end
        OP_LOAD: begin
          bus.wb_en   = ~ld_bad & (|h.rd_ind);
          bus.exc_out = ld_bad;
          bus.wb_ind  = h.rd_ind;
          bus.wb_dat  = ld_val;
        end
        OP_STORE: ;
        OP_BRANCH: begin
          bus.jmp_take_out = h.jmp_take;
          bus.jmp_addr_out = h.jmp_addr;
        end
        OP_JUMP: begin
          bus.jmp_take_out = 1'b1;
          bus.jmp_addr_out = h.jmp_addr;
          bus.wb_en        = |h.rd_ind;
          bus.wb_ind       = h.rd_ind;
          bus.wb_dat       = h.rd_dat;
        end
        default: bus.exc_out = 1'b1;
      endcase
    end
  end
endmodule
